// File: rtl/magma_decoder.sv
// magma_decoder: GOST R 34.12-2015 Magma decryption, 32 rounds pipelined as 64 stages behind an input register.
// Define MAGMA_DECODER_VALID_EN to add in_valid/out_valid tracking alongside the data.
module magma_decoder (
    input  logic         clk,
    input  logic         rst,
`ifdef MAGMA_DECODER_VALID_EN
    input  logic         in_valid,
    output logic         out_valid,
`endif
    input  logic [63:0]  encoded,
    input  logic [255:0] key,
    output logic [63:0]  block
);
    localparam logic [63:0] SBOX [8] = '{
        64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
    };

    function automatic logic [31:0] g_mix(input logic [31:0] t, input logic [31:0] a1);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            s[4*i +: 4] = 4'(SBOX[i] >> (4 * (15 - int'(t[4*i +: 4]))));
        return {s[20:0], s[31:21]} ^ a1;
    endfunction

    // decryption schedule: K1..K8 once, then K8..K1 for the remaining 24 rounds
    function automatic logic [31:0] round_key(input logic [255:0] k, input int r);
        int i;
        i = (r < 8) ? r : 7 - (r % 8);
        return 32'(k >> (32 * (7 - i)));
    endfunction

    logic [63:0]  x_d  [33];
    logic [63:0]  x_q  [33];
    logic [255:0] kx_d [32];
    logic [255:0] kx_q [32];
    logic [31:0]  t_d  [32];
    logic [31:0]  t_q  [32];
    logic [63:0]  y_d  [32];
    logic [63:0]  y_q  [32];
    logic [255:0] ky_d [31];
    logic [255:0] ky_q [31];
`ifdef MAGMA_DECODER_VALID_EN
    logic [64:0]  v_d, v_q;
`endif

    always_comb begin
        x_d[0]  = encoded;
        kx_d[0] = key;
        for (int r = 0; r < 32; r++) begin
            t_d[r] = x_q[r][31:0] + round_key(kx_q[r], r);
            y_d[r] = x_q[r];
        end
        for (int r = 0; r < 31; r++) begin
            ky_d[r]     = kx_q[r];
            kx_d[r + 1] = ky_q[r];
            x_d[r + 1]  = {y_q[r][31:0], g_mix(t_q[r], y_q[r][63:32])};
        end
        x_d[32] = {g_mix(t_q[31], y_q[31][63:32]), y_q[31][31:0]};
`ifdef MAGMA_DECODER_VALID_EN
        v_d = {v_q[63:0], in_valid};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 33; r++) x_q[r] <= '0;
            for (int r = 0; r < 32; r++) begin
                kx_q[r] <= '0;
                t_q[r]  <= '0;
                y_q[r]  <= '0;
            end
            for (int r = 0; r < 31; r++) ky_q[r] <= '0;
`ifdef MAGMA_DECODER_VALID_EN
            v_q <= '0;
`endif
        end else begin
            for (int r = 0; r < 33; r++) x_q[r] <= x_d[r];
            for (int r = 0; r < 32; r++) begin
                kx_q[r] <= kx_d[r];
                t_q[r]  <= t_d[r];
                y_q[r]  <= y_d[r];
            end
            for (int r = 0; r < 31; r++) ky_q[r] <= ky_d[r];
`ifdef MAGMA_DECODER_VALID_EN
            v_q <= v_d;
`endif
        end
    end

    assign block = x_q[32];
`ifdef MAGMA_DECODER_VALID_EN
    assign out_valid = v_q[64];
`endif
endmodule

// File: tb/tb_magma_decoder.sv
// tb_magma_decoder: directed and random vectors checked each cycle against a software Magma model.
module tb_magma_decoder;
    localparam logic [255:0] STD_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  STD_ENC = 64'h4ee901e5c2d8ca3d;
    localparam logic [63:0]  STD_PT  = 64'hfedcba9876543210;
    localparam int N = 4096;
    localparam logic [63:0] PI [8] = '{
        64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [63:0]  encoded = '0;
    logic [255:0] key = '0;
    logic [63:0]  block;
`ifdef MAGMA_DECODER_VALID_EN
    logic         out_valid;
`endif

    magma_decoder dut (
        .clk(clk),
        .rst(rst),
`ifdef MAGMA_DECODER_VALID_EN
        .in_valid(in_valid),
        .out_valid(out_valid),
`endif
        .encoded(encoded),
        .key(key),
        .block(block)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] g(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] t, s;
        logic [63:0] row;
        int n;
        t = a + k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            row = PI[i];
            n = int'(t[4*i +: 4]);
            s[4*i +: 4] = row[63 - 4*n -: 4];
        end
        return (s << 11) | (s >> 21);
    endfunction

    // decryption uses the encryption key schedule read backwards
    function automatic logic [63:0] magma(input logic [63:0] x, input logic [255:0] k, input bit dec);
        logic [31:0] a1, a0, tmp, rk;
        int step, ki;
        a1 = x[63:32];
        a0 = x[31:0];
        for (int r = 0; r < 32; r++) begin
            step = dec ? 31 - r : r;
            ki = (step < 24) ? step % 8 : 7 - (step % 8);
            rk = 32'(k >> (32 * (7 - ki)));
            tmp = g(rk, a0) ^ a1;
            if (r < 31) begin
                a1 = a0;
                a0 = tmp;
            end else a1 = tmp;
        end
        return {a1, a0};
    endfunction

    logic [63:0]  h_enc [N];
    logic [255:0] h_key [N];
    logic         h_v   [N];
    int edges = 0;
    int last_rst = -1;

    always @(posedge clk) begin
        if (edges < N) begin
            h_enc[edges] <= encoded;
            h_key[edges] <= key;
            h_v[edges]   <= in_valid;
        end
        if (rst) last_rst <= edges;
        edges <= edges + 1;
    end

    always @(negedge clk) begin : cmp
        int e;
        logic [63:0] exp_v;
        if (edges > 0 && edges <= N) begin
            e = edges - 1;
            if (e == last_rst) chk("reset_block", block, 64'd0);
            else if (e - 64 > last_rst) begin
                chk("stream_dec", block, magma(h_enc[e-64], h_key[e-64], 1'b1));
                chk("round_trip", magma(block, h_key[e-64], 1'b0), h_enc[e-64]);
            end
            exp_v = 64'd0;
            if (e != last_rst && e - 64 > last_rst) exp_v = {63'd0, h_v[e-64]};
`ifdef MAGMA_DECODER_VALID_EN
            chk("out_valid", {63'd0, out_valid}, exp_v);
`else
            if (exp_v > 64'd1) chk("valid_hist", exp_v, 64'd0);
`endif
        end
    end

    task automatic drive(input logic [63:0] e, input logic [255:0] k, input logic v);
        encoded = e;
        key = k;
        in_valid = v;
    endtask

    initial begin
        chk("model_dec", magma(STD_ENC, STD_KEY, 1'b1), STD_PT);
        chk("model_enc", magma(STD_PT, STD_KEY, 1'b0), STD_ENC);
        chk("model_zero_rt", magma(magma(64'd0, 256'd0, 1'b1), 256'd0, 1'b0), 64'd0);
        repeat (3) @(negedge clk);
        chk("reset_state", block, 64'd0);
`ifdef MAGMA_DECODER_VALID_EN
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
`endif
        rst = 1'b0;
        drive(STD_ENC, STD_KEY, 1'b1);
        @(negedge clk);
        drive(64'd0, 256'd0, 1'b0);
        repeat (64) @(negedge clk);
        chk("key_isolation", block, STD_PT);
        drive(STD_ENC, STD_KEY, 1'b1);
        repeat (10) @(negedge clk);
        drive(64'hffffffffffffffff, {256{1'b1}}, 1'b1);
        repeat (55) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("streaming", block, STD_PT);
            @(negedge clk);
        end
        drive(64'h0123456789abcdef, STD_KEY, 1'b1);
        repeat (70) @(negedge clk);
        drive(STD_ENC, STD_KEY, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            drive({$urandom, $urandom}, {8{$urandom}}, 1'b1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midflight_reset", block, 64'd0);
        @(negedge clk);
        chk("midflight_reset2", block, 64'd0);
        rst = 1'b0;
        drive(STD_ENC, STD_KEY, 1'b0);
        repeat (70) @(negedge clk);
`ifdef MAGMA_DECODER_VALID_EN
        chk("valid_after_reset", {63'd0, out_valid}, 64'd0);
`endif
        for (int i = 0; i < 1000; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom}, 1'(i % 7 != 3));
            @(negedge clk);
        end
        drive(64'd0, 256'd0, 1'b0);
        repeat (70) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/magma_decoder.md
MAGMA_DECODER -- requirements
Module: magma_decoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, per the codebase port names clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 encoded  input  64  ciphertext block, sampled on every rising edge.
REQ-006 key  input  256  cipher key, sampled together with encoded.
REQ-007 block  output  64  decrypted plaintext, registered.

Function
REQ-008 The block SHALL implement GOST R 34.12-2015 Magma decryption: 64-bit block, 256-bit key, 32 rounds.
REQ-009 Round keys SHALL be K1=key[255:224], K2=key[223:192], …, K8=key[31:0].
REQ-010 Decryption round-key order SHALL be K1..K8, then K8..K1 three times (32 rounds).
REQ-011 State split SHALL be a1=encoded[63:32] and a0=encoded[31:0].
REQ-012 Round function g(k,a) SHALL be: t=(a+k) mod 2^32; nibble i of t (bits 4i+3:4i) through S-box pi_i; then rotate left by 11.
REQ-013 S-boxes, hex, index 0..F:
  pi0 C46 2A5 B9E 8D7 03F 1
  pi1 682 39A 5C1 E47 BD0 F
  pi2 B35 82F ADE 174 C96 0
  pi3 C82 1D4 F67 0A5 3E9 B
  pi4 7F5 A81 6D0 93E B42 C
  pi5 5DF 692 CAB 781 43E 0
  pi6 8E2 569 1CF 4B0 DA3 7
  pi7 17E D05 834 FA6 9CB 2
REQ-014 Rounds 1..31 SHALL map (a1,a0) to (a0, g(k,a0) xor a1); round 32 SHALL output {g(k,a0) xor a1, a0} with no swap.
REQ-015 Each round SHALL be split into 2 register stages: stage 1 registers the modular add; stage 2 registers the S-box, rotate, xor and swap.
REQ-016 The datapath SHALL be fully pipelined with 64 stages, throughput one block per cycle, and latency exactly 64 cycles from the sampling edge to the block update.
REQ-017 The key SHALL travel down the pipeline with its block, so each block is decrypted only with the key sampled with it; key changes on later cycles SHALL NOT affect blocks already in flight.
REQ-018 No handshake SHALL exist in the base configuration; every cycle's input is processed.

Reset
REQ-019 While rst=1 at a rising edge, all pipeline registers and block SHALL be cleared to 0.
REQ-020 After rst deasserts, block SHALL be don't-care until 64 cycles after the first post-reset input is sampled (unless REQ-022 applies).
REQ-021 Reset asserted mid-operation SHALL discard all in-flight blocks.

Configuration
REQ-022 With MAGMA_DECODER_VALID_EN defined, the block SHALL add in_valid (input, 1) and out_valid (output, 1); in_valid SHALL be piped alongside the data with a 64-cycle delay into out_valid; out_valid SHALL reset to 0; the data path SHALL be unchanged.
REQ-023 Without MAGMA_DECODER_VALID_EN, those ports and the valid pipeline SHALL be absent.

Verification
REQ-024 Standard vector: key=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, encoded=4ee901e5c2d8ca3d -> block=fedcba9876543210 exactly 64 cycles later.
REQ-025 Streaming: standard vector held for 10 consecutive cycles -> 10 consecutive outputs of fedcba9876543210 starting at cycle 64.
REQ-026 Key isolation: standard vector for 1 cycle, then key=0 and encoded=0 -> cycle-64 output is still fedcba9876543210.
REQ-027 Reset mid-flight: assert rst 20 cycles after the standard vector -> block=0 during reset; with VALID_EN, out_valid stays 0 until 64 cycles after the next in_valid.
REQ-028 Random: 1000 back-to-back random key/encoded pairs -> every output matches a software Magma decrypt at +64 cycles, and software-encrypting each output reproduces its input.
